// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - run control, halt capture and register-file dump for the MIPS core
// Define MIPS_RUN_MONITOR_CHECKSUM_EN to add the dump_sum output.
module mips_run_monitor #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int IDX_W     = 5,
  parameter int PC_W      = 32,
  parameter int MAX_CYC   = 820,
  parameter int STALL_CYC = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   pc_in,
  output logic              cpu_run,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic [PC_W-1:0]   final_pc,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycles,
`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
  output logic [DATA_W-1:0] dump_sum,
`endif
  output logic              done
);

  localparam int SW       = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam int STALL_M1 = (STALL_CYC > 0) ? STALL_CYC - 1 : 0;
  localparam int MAX_M1   = (MAX_CYC > 0) ? MAX_CYC - 1 : 0;

  if (NUM_REGS < 2) begin : g_chk_regs
    $error("NUM_REGS must be at least 2");
  end
  if ((64'd1 << IDX_W) < 64'(NUM_REGS)) begin : g_chk_idx
    $error("IDX_W too narrow for NUM_REGS");
  end
  if (64'(MAX_CYC) >= (64'd1 << CNT_W)) begin : g_chk_budget
    $error("MAX_CYC must be below 2**CNT_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_ADDR, S_DATA, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
  logic [PC_W-1:0]   final_pc_q, final_pc_d;
  logic [1:0]        cause_q, cause_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;

  logic launch, accept, pc_eq, budget_hit, stall_hit;

  assign launch     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept     = (state_q == S_SEND) && dump_ready;
  assign pc_eq      = (pc_in == prev_pc_q);
  assign budget_hit = (MAX_CYC != 0) && (cycles_q == CNT_W'(MAX_M1));
  // Counter holds the number of equal cycles already seen, so this cycle is the STALL_CYC-th.
  assign stall_hit  = (STALL_CYC != 0) && pc_eq && (stall_q == SW'(STALL_M1));

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    stall_d     = stall_q;
    prev_pc_d   = prev_pc_q;
    final_pc_d  = final_pc_q;
    cause_d     = cause_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    dump_last_d = dump_last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          cycles_d   = '0;
          stall_d    = '0;
          prev_pc_d  = pc_in;
          final_pc_d = '0;
          cause_d    = 2'b00;
          idx_d      = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
        stall_d   = pc_eq ? stall_q + SW'(1) : '0;
        prev_pc_d = pc_in;
        if (budget_hit || stall_hit) begin
          final_pc_d = pc_in;
          cause_d    = {stall_hit, budget_hit};
          state_d    = S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        dump_data_d = rf_rdata;
        dump_idx_d  = idx_q;
        dump_last_d = (idx_q == IDX_W'(NUM_REGS - 1));
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          dump_last_d = 1'b0;
          if (dump_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cycles_q    <= '0;
      stall_q     <= '0;
      prev_pc_q   <= '0;
      final_pc_q  <= '0;
      cause_q     <= 2'b00;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      dump_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      stall_q     <= stall_d;
      prev_pc_q   <= prev_pc_d;
      final_pc_q  <= final_pc_d;
      cause_q     <= cause_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      dump_last_q <= dump_last_d;
    end
  end

`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (launch)      sum_d = '0;
    else if (accept) sum_d = sum_q + dump_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign dump_sum = sum_q;
`endif

  assign cpu_run    = (state_q == S_RUN);
  assign rf_raddr   = idx_q;
  assign dump_valid = (state_q == S_SEND);
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
  assign final_pc   = final_pc_q;
  assign halt_cause = cause_q;
  assign cycles     = cycles_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - scoreboard bench for mips_run_monitor
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        cpu_run;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = 32'd0;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;
  logic [31:0] final_pc;
  logic [1:0]  halt_cause;
  logic [15:0] cycles;
  logic        done;
`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
  logic [31:0] dump_sum;
`endif

  mips_run_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in), .cpu_run(cpu_run),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .final_pc(final_pc), .halt_cause(halt_cause),
    .cycles(cycles),
`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
    .dump_sum(dump_sum),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  cause;
    logic [15:0] cyc;
    int          runc;
    logic [31:0] sum;
  } res_t;

  beat_t       beat_q[$];
  res_t        res_q[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;
  int          run_k = 0;
  int          pc_k = 0;
  int          freeze_k = 0;
  int          bp_left = 0;
  bit          bp_arm = 1'b0;

  always @(posedge clk) rf_rdata <= rf[rf_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cpu_run"}, 64'(cpu_run), 0);
    chk({tag, "_dump_valid"}, 64'(dump_valid), 0);
    chk({tag, "_dump_idx"}, 64'(dump_idx), 0);
    chk({tag, "_dump_data"}, 64'(dump_data), 0);
    chk({tag, "_dump_last"}, 64'(dump_last), 0);
    chk({tag, "_final_pc"}, 64'(final_pc), 0);
    chk({tag, "_halt_cause"}, 64'(halt_cause), 0);
    chk({tag, "_cycles"}, 64'(cycles), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rf_raddr"}, 64'(rf_raddr), 0);
`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
    chk({tag, "_dump_sum"}, 64'(dump_sum), 0);
`endif
  endtask

  function automatic logic [31:0] rf_sum();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 32; i++) s = s + rf[i];
    return s;
  endfunction

  task automatic push_run(input logic [31:0] pc, input logic [1:0] cause,
                          input logic [15:0] cyc, input int runc, input logic [31:0] sum);
    beat_t b;
    res_t  r;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = rf[i];
      b.last = (i == 31);
      beat_q.push_back(b);
    end
    r.pc = pc; r.cause = cause; r.cyc = cyc; r.runc = runc; r.sum = sum;
    res_q.push_back(r);
  endtask

  task automatic start_run(input int freeze);
    @(negedge clk);
    freeze_k = freeze;
    pc_k     = 0;
    pc_in    = 32'd0;
    run_k    = 0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #3;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_reached"}, 64'(seen), 1);
    repeat (2) @(negedge clk);
  endtask

  // Core model: PC advances by 4 per RUN cycle until it freezes at 4*freeze_k.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_run) begin
        pc_k++;
        pc_in = 32'(4 * ((pc_k < freeze_k) ? pc_k : freeze_k));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bp_left > 0) begin
        dump_ready = 1'b0;
        bp_left--;
      end else begin
        dump_ready = 1'b1;
        if (bp_arm && dump_valid && dump_idx == 5'd3) begin
          dump_ready = 1'b0;
          bp_left    = 4;
          bp_arm     = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected beats on handshake, expected run results when done rises.
  initial begin
    bit          hold = 1'b0;
    bit          done_prev = 1'b0;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    logic        h_last;
    beat_t       b;
    res_t        r;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        hold = 1'b0;
        done_prev = 1'b0;
        continue;
      end
      if (cpu_run) run_k++;
      if (hold) begin
        chk("hold_valid", 64'(dump_valid), 1);
        chk("hold_idx", 64'(dump_idx), 64'(h_idx));
        chk("hold_data", 64'(dump_data), 64'(h_data));
        chk("hold_last", 64'(dump_last), 64'(h_last));
      end
      hold = dump_valid && !dump_ready;
      h_idx = dump_idx; h_data = dump_data; h_last = dump_last;
      if (dump_valid && dump_ready) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat_idx", 64'(dump_idx), 64'hFFFF);
        end else begin
          b = beat_q.pop_front();
          chk("beat_idx", 64'(dump_idx), 64'(b.idx));
          chk("beat_data", 64'(dump_data), 64'(b.data));
          chk("beat_last", 64'(dump_last), 64'(b.last));
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 0);
        end else begin
          r = res_q.pop_front();
          chk("final_pc", 64'(final_pc), 64'(r.pc));
          chk("halt_cause", 64'(halt_cause), 64'(r.cause));
          chk("cycles", 64'(cycles), 64'(r.cyc));
          chk("run_cycles_seen", 64'(run_k), 64'(r.runc));
          chk("beats_missing", 64'(beat_q.size()), 0);
          chk("cpu_run_at_done", 64'(cpu_run), 0);
`ifdef MIPS_RUN_MONITOR_CHECKSUM_EN
          chk("dump_sum", 64'(dump_sum), 64'(r.sum));
`endif
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1000000;
    failures++;
    checks++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit hit;
    for (int i = 0; i < 32; i++) rf[i] = (32'(i) << 24) ^ 32'(2 * i + 1);
    rf[3] = 32'h0000_0007;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Self-loop at 0x28: equal from RUN cycle 10, 8th equal cycle is 17 -> 18 cycles.
    bp_arm = 1'b1;
    push_run(32'h28, 2'b10, 16'd18, 18, rf_sum());
    start_run(10);
    wait_done("stall");

    // Non-stalling loop hits the 820-cycle budget; a mid-run start is ignored.
    push_run(32'd3280, 2'b01, 16'd820, 820, rf_sum());
    start_run(1000000);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("budget");

    // PC freezes from RUN cycle 812; 8th equal cycle coincides with budget cycle 819.
    push_run(32'd3248, 2'b11, 16'd820, 820, rf_sum());
    start_run(812);
    wait_done("both");

    // Abort with reset while beat 12 is on offer.
    push_run(32'h28, 2'b10, 16'd18, 18, rf_sum());
    start_run(10);
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #3;
      if (dump_valid && dump_idx == 5'd12) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_idx12", 64'(hit), 1);
    rst_n = 1'b0;
    #1 check_zero("midrst");
    beat_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean run after reset; $t0=5, $t1=0xFFFFFFFF sums to 4.
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[8] = 32'd5;
    rf[9] = 32'hFFFF_FFFF;
    push_run(32'h28, 2'b10, 16'd18, 18, 32'h0000_0004);
    start_run(10);
    wait_done("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
